// File: rtl/rs_gf8_syndrome_serial.sv
// Serial S1/S2 syndrome calculator for RS(N_SYM,N_SYM-2) over GF(2^3), x^3+x+1.
// Symbols arrive highest-order coefficient first and are folded in by Horner recursion.
module rs_gf8_syndrome_serial #(
    parameter int N_SYM = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sym_i,
    input  logic       sym_valid_i,
    input  logic       sof_i,
    output logic [5:0] syndrome_o,
    output logic       syn_valid_o,
    output logic       error_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(N_SYM - 1);

    function automatic logic [2:0] mul_a(input logic [2:0] x);
        return {x[1], x[0] ^ x[2], x[2]};
    endfunction

    state_t     state_q, state_d;
    logic [2:0] s1_q, s1_d;
    logic [2:0] s2_q, s2_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] syndrome_q, syndrome_d;
    logic       syn_valid_q, syn_valid_d;
    logic       error_q, error_d;
    logic       frame_err_q, frame_err_d;

    logic [2:0] s1_next;
    logic [2:0] s2_next;

    assign s1_next = mul_a(s1_q) ^ sym_i;
    assign s2_next = mul_a(mul_a(s2_q)) ^ sym_i;

    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        cnt_d       = cnt_q;
        syndrome_d  = syndrome_q;
        error_d     = error_q;
        syn_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sym_valid_i) begin
                    if (sof_i) begin
                        s1_d    = sym_i;
                        s2_d    = sym_i;
                        cnt_d   = 3'd1;
                        state_d = ACCUM;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (sym_valid_i) begin
                    if (sof_i) begin
                        // A new frame start aborts the partial codeword and restarts it.
                        frame_err_d = 1'b1;
                        s1_d        = sym_i;
                        s2_d        = sym_i;
                        cnt_d       = 3'd1;
                    end else if (cnt_q == LAST_CNT) begin
                        syndrome_d  = {s2_next, s1_next};
                        error_d     = |{s2_next, s1_next};
                        syn_valid_d = 1'b1;
                        s1_d        = 3'd0;
                        s2_d        = 3'd0;
                        cnt_d       = 3'd0;
                        state_d     = IDLE;
                    end else begin
                        s1_d  = s1_next;
                        s2_d  = s2_next;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s1_q        <= 3'd0;
            s2_q        <= 3'd0;
            cnt_q       <= 3'd0;
            syndrome_q  <= 6'd0;
            syn_valid_q <= 1'b0;
            error_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            syndrome_q  <= syndrome_d;
            syn_valid_q <= syn_valid_d;
            error_q     <= error_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign syndrome_o  = syndrome_q;
    assign syn_valid_o = syn_valid_q;
    assign error_o     = error_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == ACCUM);

endmodule

// File: tb/tb_rs_gf8_syndrome_serial.sv
// Bench for rs_gf8_syndrome_serial: table vectors, corner sequences and a
// cycle-by-cycle scoreboard for N_SYM=7 and N_SYM=5 instances.
module tb_rs_gf8_syndrome_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] sym = 3'd0;
    logic       sym_valid = 1'b0;
    logic       sof = 1'b0;

    logic [5:0] syn7, syn5;
    logic       sv7, sv5, err7, err5, fe7, fe5, busy7, busy5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    rs_gf8_syndrome_serial #(.N_SYM(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .sym_i(sym), .sym_valid_i(sym_valid), .sof_i(sof),
        .syndrome_o(syn7), .syn_valid_o(sv7), .error_o(err7),
        .frame_err_o(fe7), .busy_o(busy7)
    );

    rs_gf8_syndrome_serial #(.N_SYM(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .sym_i(sym), .sym_valid_i(sym_valid), .sof_i(sof),
        .syndrome_o(syn5), .syn_valid_o(sv5), .error_o(err5),
        .frame_err_o(fe5), .busy_o(busy5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // GF(8) multiply by schoolbook product and reduction modulo x^3+x+1.
    function automatic logic [2:0] gfmul(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] p;
        p = 6'd0;
        for (int i = 0; i < 3; i++)
            if (b[i]) p = p ^ (6'({3'b0, a}) << i);
        for (int i = 4; i >= 3; i--)
            if (p[i]) p = p ^ (6'b001011 << (i - 3));
        return p[2:0];
    endfunction

    function automatic logic [2:0] apow(input int e);
        logic [2:0] r;
        r = 3'd1;
        for (int i = 0; i < (e % 7); i++) r = gfmul(r, 3'b010);
        return r;
    endfunction

    // Reference model: buffer the accepted frame, then evaluate r(alpha^j) directly.
    logic [2:0] frm [2][8];
    int         len [2];
    logic [5:0] m_syn [2];
    logic       m_err [2];
    logic       m_sv [2];
    logic       m_fe [2];

    function automatic logic [5:0] syn_of(input int k, input int n);
        logic [2:0] s1, s2;
        s1 = 3'd0;
        s2 = 3'd0;
        for (int i = 0; i < n; i++) begin
            s1 = s1 ^ gfmul(frm[k][n-1-i], apow(i));
            s2 = s2 ^ gfmul(frm[k][n-1-i], apow(2 * i));
        end
        return {s2, s1};
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            len[k] = 0; m_syn[k] = 6'd0; m_err[k] = 1'b0; m_sv[k] = 1'b0; m_fe[k] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                int n;
                n = (k == 0) ? 7 : 5;
                m_sv[k] = 1'b0;
                m_fe[k] = 1'b0;
                if (!rst_n) begin
                    len[k] = 0; m_syn[k] = 6'd0; m_err[k] = 1'b0;
                end else if (sym_valid) begin
                    if (sof) begin
                        if (len[k] != 0) m_fe[k] = 1'b1;
                        frm[k][0] = sym;
                        len[k] = 1;
                    end else if (len[k] == 0) begin
                        m_fe[k] = 1'b1;
                    end else begin
                        frm[k][len[k]] = sym;
                        len[k]++;
                        if (len[k] == n) begin
                            m_syn[k] = syn_of(k, n);
                            m_err[k] = (m_syn[k] != 6'd0);
                            m_sv[k]  = 1'b1;
                            len[k]   = 0;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int         sv_cnt7 = 0, fe_cnt7 = 0;
    int         last_sv_cyc = 0, prev_sv_cyc = 0;
    logic [5:0] last_syn7 = 6'd0, prev_syn7 = 6'd0;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("syn7", int'(syn7), int'(m_syn[0]));
            chk("sv7", int'(sv7), int'(m_sv[0]));
            chk("err7", int'(err7), int'(m_err[0]));
            chk("fe7", int'(fe7), int'(m_fe[0]));
            chk("busy7", int'(busy7), int'(len[0] != 0));
            chk("syn5", int'(syn5), int'(m_syn[1]));
            chk("sv5", int'(sv5), int'(m_sv[1]));
            chk("err5", int'(err5), int'(m_err[1]));
            chk("fe5", int'(fe5), int'(m_fe[1]));
            chk("busy5", int'(busy5), int'(len[1] != 0));
            if (sv7) begin
                sv_cnt7++;
                prev_sv_cyc = last_sv_cyc;
                last_sv_cyc = cyc;
                prev_syn7 = last_syn7;
                last_syn7 = syn7;
            end
            if (fe7) fe_cnt7++;
        end
    end

    typedef struct {
        logic [0:6][2:0] s;
        int              gap;
        logic [5:0]      syn;
        logic            err;
    } vec_t;

    vec_t vt [6];

    task automatic applyStimulus(input logic [2:0] s, input logic f);
        sym = s;
        sof = f;
        sym_valid = 1'b1;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp_syn, input logic exp_err);
        chk({name, "_strobe"}, int'(sv7), 1);
        chk({name, "_syn"}, int'(syn7), int'(exp_syn));
        chk({name, "_err"}, int'(err7), int'(exp_err));
    endtask

    task automatic runVec(input vec_t v, input string name);
        for (int j = 0; j < 7; j++) begin
            applyStimulus(v.s[j], j == 0);
            if (j < 6 && v.gap > 0) begin
                int g;
                g = $urandom_range(0, v.gap);
                for (int c = 0; c < g; c++) begin
                    chk({name, "_gapbusy"}, int'(busy7), 1);
                    idleCycles(1);
                end
            end
        end
        checkOutput(name, v.syn, v.err);
    endtask

    initial begin
        int svb, feb;
        vt[0] = '{s: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd6, 3'd3}, gap: 0, syn: 6'b000000, err: 1'b0};
        vt[1] = '{s: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, gap: 0, syn: 6'b001001, err: 1'b1};
        vt[2] = '{s: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, gap: 0, syn: 6'b100010, err: 1'b1};
        vt[3] = '{s: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd6, 3'd3}, gap: 5, syn: 6'b000000, err: 1'b0};
        vt[4] = '{s: '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, gap: 0, syn: 6'b000000, err: 1'b0};
        vt[5] = '{s: '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, gap: 0, syn: 6'b111101, err: 1'b1};

        #2;
        rst_n = 1'b0;
        mon_en = 1'b1;
        idleCycles(2);
        chk("rst_syn", int'(syn7), 0);
        chk("rst_sv", int'(sv7), 0);
        chk("rst_err", int'(err7), 0);
        chk("rst_fe", int'(fe7), 0);
        chk("rst_busy", int'(busy7), 0);
        rst_n = 1'b1;
        idleCycles(2);

        // Reset in the middle of a codeword must discard it silently.
        applyStimulus(3'd5, 1'b1);
        applyStimulus(3'd2, 1'b0);
        applyStimulus(3'd7, 1'b0);
        svb = sv_cnt7;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy7), 0);
        idleCycles(1);
        rst_n = 1'b1;
        idleCycles(3);
        chk("midrst_nostrobe", sv_cnt7, svb);
        runVec(vt[1], "after_rst");
        idleCycles(2);

        for (int i = 0; i < 6; i++) begin
            runVec(vt[i], $sformatf("vec%0d", i));
            idleCycles(2);
        end

        // sof re-asserted on the 4th symbol, then a full r0-error codeword.
        feb = fe_cnt7;
        svb = sv_cnt7;
        applyStimulus(3'd4, 1'b1);
        applyStimulus(3'd2, 1'b0);
        applyStimulus(3'd6, 1'b0);
        runVec(vt[1], "resof");
        idleCycles(2);
        chk("resof_fe_count", fe_cnt7 - feb, 1);
        chk("resof_sv_count", sv_cnt7 - svb, 1);

        // Stray symbol in IDLE: flagged and otherwise ignored.
        feb = fe_cnt7;
        applyStimulus(3'd5, 1'b0);
        chk("stray_fe", int'(fe7), 1);
        chk("stray_busy", int'(busy7), 0);
        idleCycles(2);
        chk("stray_fe_count", fe_cnt7 - feb, 1);
        chk("stray_syn_hold", int'(syn7), int'(6'b001001));

        // Back-to-back codewords with no bubble.
        for (int j = 0; j < 7; j++) applyStimulus(vt[0].s[j], j == 0);
        for (int j = 0; j < 7; j++) applyStimulus(vt[1].s[j], j == 0);
        idleCycles(2);
        chk("b2b_spacing", last_sv_cyc - prev_sv_cyc, 7);
        chk("b2b_first", int'(prev_syn7), 0);
        chk("b2b_second", int'(last_syn7), int'(6'b001001));

        // Randomized traffic checked only by the scoreboard.
        for (int f = 0; f < 25; f++) begin
            int flen;
            if ($urandom_range(0, 4) == 0) applyStimulus(3'($urandom), 1'b0);
            flen = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 7;
            for (int j = 0; j < flen; j++) begin
                applyStimulus(3'($urandom), j == 0);
                idleCycles($urandom_range(0, 2));
            end
        end
        idleCycles(3);

        // N_SYM=5 instance: x^2 * g(x) is a valid codeword.
        applyStimulus(3'd1, 1'b1);
        applyStimulus(3'd6, 1'b0);
        applyStimulus(3'd3, 1'b0);
        applyStimulus(3'd0, 1'b0);
        applyStimulus(3'd0, 1'b0);
        chk("n5_strobe", int'(sv5), 1);
        chk("n5_syn", int'(syn5), 0);
        chk("n5_err", int'(err5), 0);
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
